// File: rtl/hazard_control_unit.sv
// Hazard sequencer for the 5-stage core: load-use stalls, branch flushes,
// data-memory wait freezing with a sticky timeout, and a saturating stall counter.
module hazard_control_unit #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             id_ex_memread,
    input  logic [4:0]       id_ex_rd,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_flush,
    output logic             ex_mem_write,
    output logic             mem_wb_bubble,
    output logic [CNT_W-1:0] stall_count,
    output logic             mem_timeout_err,
    output logic [1:0]       hz_state
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2,
        ERROR      = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic [CNT_W-1:0] stall_count_reg;
    logic             err_reg;

    // Per-source comparison of the ID operands against the load destination.
    logic [4:0] src_rs  [2];
    logic [1:0] src_use;
    logic [1:0] src_hit;
    logic       load_use;

    assign src_rs[0]  = id_rs1;
    assign src_rs[1]  = id_rs2;
    assign src_use[0] = id_uses_rs1;
    assign src_use[1] = id_uses_rs2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign src_hit[gi] = src_use[gi] && (src_rs[gi] == id_ex_rd);
        end
    endgenerate

    assign load_use = id_ex_memread && (id_ex_rd != 5'd0) && (|src_hit);

    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_write   = 1'b1;
        id_ex_flush   = 1'b0;
        ex_mem_write  = 1'b1;
        mem_wb_bubble = 1'b0;
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;

        case (state_reg)
            RUN, LOAD_STALL: begin
                if (mem_req && !mem_ready) begin
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    id_ex_write   = 1'b0;
                    ex_mem_write  = 1'b0;
                    mem_wb_bubble = 1'b1;
                    state_next    = MEM_WAIT;
                    wait_cnt_next = CNT_W'(1);
                end else if (ex_branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    state_next  = RUN;
                end else if (state_reg == RUN && load_use) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                    state_next  = LOAD_STALL;
                end else begin
                    state_next = RUN;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_next    = RUN;
                    wait_cnt_next = '0;
                end else begin
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    id_ex_write   = 1'b0;
                    ex_mem_write  = 1'b0;
                    mem_wb_bubble = 1'b1;
                    if (wait_cnt_reg == TIMEOUT_VAL) begin
                        state_next = ERROR;
                    end else begin
                        wait_cnt_next = wait_cnt_reg + CNT_W'(1);
                    end
                end
            end
            default: begin
                pc_write      = 1'b0;
                if_id_write   = 1'b0;
                id_ex_write   = 1'b0;
                ex_mem_write  = 1'b0;
                mem_wb_bubble = 1'b1;
                state_next    = ERROR;
            end
        endcase

        // Reset forces every pipeline control low regardless of state.
        if (rst) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            if_id_flush   = 1'b0;
            id_ex_write   = 1'b0;
            id_ex_flush   = 1'b0;
            ex_mem_write  = 1'b0;
            mem_wb_bubble = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= RUN;
            wait_cnt_reg    <= '0;
            stall_count_reg <= '0;
            err_reg         <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (!pc_write && stall_count_reg != CNT_MAX) begin
                stall_count_reg <= stall_count_reg + CNT_W'(1);
            end
            if (state_next == ERROR) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign stall_count     = stall_count_reg;
    assign mem_timeout_err = err_reg;
    assign hz_state        = state_reg;

endmodule
